// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter that shares one SHA-256 core between NREQ requesters, feeding each granted
// job into the core block by block and aborting a block that hangs longer than WDOG cycles.
module sha256_job_arbiter #(
   parameter int NREQ = 2,
   parameter int BLKW = 8,
   parameter int WDOG = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*BLKW-1:0] req_nblk,
   output logic [NREQ-1:0]      gnt,
   output logic                 blk_req,
   input  logic                 blk_ack,
   output logic                 core_start,
   output logic                 core_first,
   output logic                 core_last,
   input  logic                 core_busy,
   output logic [NREQ-1:0]      done,
   output logic                 err,
   output logic                 busy
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW  = $clog2(WDOG + 1);
   localparam logic [WDW-1:0]  WDOG_LAST = WDW'(WDOG - 1);
   localparam logic [WDW-1:0]  WDOG_MAX  = WDW'(WDOG);
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NREQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      WAIT,
      DONE,
      ERR
   } state_t;

   state_t          state;
   logic [IDXW-1:0] ptr;
   logic [IDXW-1:0] gidx;
   logic [IDXW-1:0] pick_idx;
   logic [IDXW-1:0] next_ptr;
   logic            pick_valid;
   logic [BLKW-1:0] pick_nblk;
   logic [BLKW-1:0] nblk;
   logic [BLKW-1:0] blk_idx;
   logic [WDW-1:0]  wdog_cnt;
   logic            seen_busy;
   logic            is_last;

   // First requester at or after the pointer, wrapping around the requester ring.
   always_comb begin
      int              j;
      logic [IDXW-1:0] cand;
      pick_valid = 1'b0;
      pick_idx   = '0;
      j          = 0;
      cand       = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ) begin
            j = j - NREQ;
         end
         cand = IDXW'(j);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // A zero block count still describes a one-block job.
   always_comb begin
      pick_nblk = req_nblk[int'(pick_idx)*BLKW +: BLKW];
      if (pick_nblk == '0) begin
         pick_nblk = BLKW'(1);
      end
   end

   assign next_ptr = (gidx == IDX_LAST) ? '0 : gidx + 1'b1;
   assign is_last  = (blk_idx == nblk - 1'b1);

   // Job sequencer; every output is a register updated together with the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ptr        <= '0;
         gidx       <= '0;
         nblk       <= '0;
         blk_idx    <= '0;
         wdog_cnt   <= '0;
         seen_busy  <= 1'b0;
         gnt        <= '0;
         blk_req    <= 1'b0;
         core_start <= 1'b0;
         core_first <= 1'b0;
         core_last  <= 1'b0;
         done       <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         core_start <= 1'b0;
         core_first <= 1'b0;
         core_last  <= 1'b0;
         done       <= '0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state     <= FETCH;
                  gnt       <= NREQ'(1) << pick_idx;
                  gidx      <= pick_idx;
                  nblk      <= pick_nblk;
                  blk_idx   <= '0;
                  wdog_cnt  <= '0;
                  seen_busy <= 1'b0;
                  blk_req   <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            FETCH: begin
               if (blk_ack) begin
                  state      <= START;
                  blk_req    <= 1'b0;
                  core_start <= 1'b1;
                  core_first <= (blk_idx == '0);
                  core_last  <= is_last;
               end
            end
            START: begin
               state <= WAIT;
            end
            WAIT: begin
               if (core_busy) begin
                  seen_busy <= 1'b1;
               end
               // A block is finished only once the core has been seen busy and then idle again.
               if (!core_busy && seen_busy) begin
                  seen_busy <= 1'b0;
                  wdog_cnt  <= '0;
                  if (is_last) begin
                     state <= DONE;
                     done  <= gnt;
                  end else begin
                     state   <= FETCH;
                     blk_idx <= blk_idx + 1'b1;
                     blk_req <= 1'b1;
                  end
               end else if (wdog_cnt == WDOG_LAST) begin
                  state     <= ERR;
                  err       <= 1'b1;
                  wdog_cnt  <= '0;
                  seen_busy <= 1'b0;
               end else if (wdog_cnt != WDOG_MAX) begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
            end
            DONE, ERR: begin
               state <= IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
               ptr   <= next_ptr;
            end
            default: begin
               state   <= IDLE;
               gnt     <= '0;
               blk_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Bench for sha256_job_arbiter: a table of jobs run against a small core model, with expected
// core_start and done/err events queued at stimulus time and checked as the arbiter emits them.
`timescale 1ns/1ps
module tb_sha256_job_arbiter;

   localparam int NREQ = 2;
   localparam int BLKW = 8;
   localparam int WDOG = 100;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ*BLKW-1:0] req_nblk;
   logic [NREQ-1:0]      gnt;
   logic                 blk_req;
   logic                 blk_ack;
   logic                 core_start;
   logic                 core_first;
   logic                 core_last;
   logic                 core_busy;
   logic [NREQ-1:0]      done;
   logic                 err;
   logic                 busy;

   typedef struct {
      logic [NREQ-1:0] gnt;
      logic            first;
      logic            last;
   } startExp_t;

   typedef struct {
      logic [NREQ-1:0] done;
      logic            err;
      logic [NREQ-1:0] gnt;
      int              delay;
   } endExp_t;

   typedef struct {
      int who;
      int nblk;
      int busyLen;
      int ackDly;
      bit stuck;
      int expStarts;
      int expLastIdx;
      bit expErr;
   } vec_t;

   startExp_t startQ[$];
   endExp_t   endQ[$];
   startExp_t sRec;
   endExp_t   eRec;
   vec_t      vecs[6];
   vec_t      quick;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int lastStartCyc = 0;
   int startCount = 0;
   int busyLen = 2;
   int ackDly = 0;
   bit stuck = 1'b0;
   int ackWait = -1;
   int busyLeft = 0;

   sha256_job_arbiter #(
      .NREQ(NREQ),
      .BLKW(BLKW),
      .WDOG(WDOG)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .req_nblk(req_nblk),
      .gnt(gnt),
      .blk_req(blk_req),
      .blk_ack(blk_ack),
      .core_start(core_start),
      .core_first(core_first),
      .core_last(core_last),
      .core_busy(core_busy),
      .done(done),
      .err(err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Core and requester data model: acks blk_req after ackDly cycles, holds core_busy busyLen cycles.
   initial begin
      blk_ack   = 1'b0;
      core_busy = 1'b0;
      forever begin
         @(negedge clk);
         blk_ack = 1'b0;
         if (!reset) begin
            core_busy = 1'b0;
            ackWait   = -1;
            busyLeft  = 0;
         end else begin
            if (blk_req) begin
               if (ackWait < 0) ackWait = ackDly;
               if (ackWait == 0) begin
                  blk_ack = 1'b1;
                  ackWait = -1;
               end else begin
                  ackWait--;
               end
            end
            if (err) begin
               core_busy = 1'b0;
            end else if (core_busy && !stuck) begin
               busyLeft--;
               if (busyLeft <= 0) core_busy = 1'b0;
            end
            if (core_start) begin
               core_busy = 1'b1;
               busyLeft  = busyLen;
            end
         end
      end
   end

   // Scoreboard side: pop and compare whenever the arbiter emits a start or a job end.
   always @(negedge clk) begin
      if (reset && core_start) begin
         if (startQ.size() == 0) begin
            checkOutput("unexpected core_start", 32'(core_start), 32'd0);
         end else begin
            sRec = startQ.pop_front();
            checkOutput("start gnt", 32'(gnt), 32'(sRec.gnt));
            checkOutput("start first", 32'(core_first), 32'(sRec.first));
            checkOutput("start last", 32'(core_last), 32'(sRec.last));
         end
         lastStartCyc = cyc;
         startCount++;
      end
      if (reset && (done != '0 || err)) begin
         if (endQ.size() == 0) begin
            checkOutput("unexpected done/err", 32'({done, err}), 32'd0);
         end else begin
            eRec = endQ.pop_front();
            checkOutput("end done", 32'(done), 32'(eRec.done));
            checkOutput("end err", 32'(err), 32'(eRec.err));
            checkOutput("end gnt", 32'(gnt), 32'(eRec.gnt));
            checkOutput("end delay", 32'(cyc - lastStartCyc), 32'(eRec.delay));
         end
      end
   end

   task automatic applyStimulus(input int who, input int nblk);
      @(negedge clk);
      req[who] = 1'b1;
      req_nblk[who*BLKW +: BLKW] = BLKW'(nblk);
   endtask

   task automatic waitEnd(input int limit, input string name);
      int n;
      n = 0;
      while (done == '0 && !err && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(done != '0 || err), 32'd1);
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, " gnt"}, 32'(gnt), 32'd0);
      checkOutput({name, " busy"}, 32'(busy), 32'd0);
      checkOutput({name, " blk_req"}, 32'(blk_req), 32'd0);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, " gnt"}, 32'(gnt), 32'd0);
      checkOutput({name, " blk_req"}, 32'(blk_req), 32'd0);
      checkOutput({name, " core_start"}, 32'(core_start), 32'd0);
      checkOutput({name, " core_first"}, 32'(core_first), 32'd0);
      checkOutput({name, " core_last"}, 32'(core_last), 32'd0);
      checkOutput({name, " done"}, 32'(done), 32'd0);
      checkOutput({name, " err"}, 32'(err), 32'd0);
      checkOutput({name, " busy"}, 32'(busy), 32'd0);
   endtask

   task automatic pushStart(input logic [NREQ-1:0] g, input logic f, input logic l);
      startExp_t se;
      se.gnt   = g;
      se.first = f;
      se.last  = l;
      startQ.push_back(se);
   endtask

   task automatic pushEnd(input logic [NREQ-1:0] d, input logic e, input logic [NREQ-1:0] g, input int dly);
      endExp_t ee;
      ee.done  = d;
      ee.err   = e;
      ee.gnt   = g;
      ee.delay = dly;
      endQ.push_back(ee);
   endtask

   task automatic runVector(input vec_t v);
      logic [NREQ-1:0] want;
      int              limit;
      want    = NREQ'(1) << v.who;
      busyLen = v.busyLen;
      ackDly  = v.ackDly;
      stuck   = v.stuck;
      for (int b = 0; b < v.expStarts; b++) begin
         pushStart(want, b == 0, b == v.expLastIdx);
      end
      pushEnd(v.expErr ? '0 : want, v.expErr, want, v.expErr ? WDOG + 1 : v.busyLen + 1);
      applyStimulus(v.who, v.nblk);
      @(negedge clk);
      checkOutput("grant latency gnt", 32'(gnt), 32'(want));
      checkOutput("grant latency blk_req", 32'(blk_req), 32'd1);
      req[v.who] = 1'b0;
      req_nblk[v.who*BLKW +: BLKW] = 8'h07;
      limit = (v.nblk + 1) * (v.busyLen + v.ackDly + 10) + WDOG + 50;
      waitEnd(limit, "job end seen");
      @(negedge clk);
      checkIdle("after job");
      checkOutput("starts drained", 32'(startQ.size()), 32'd0);
      checkOutput("ends drained", 32'(endQ.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global timeout reached");
      $fatal(1, "[TB] bench did not finish");
   end

   initial begin
      int base;
      int n;
      reset    = 1'b0;
      req      = '0;
      req_nblk = '0;

      //        who nblk busy ack stuck starts lastIdx err
      vecs[0] = '{0,   1,  74,  2, 1'b0,   1,     0,  1'b0};
      vecs[1] = '{1,   3,  20,  1, 1'b0,   3,     2,  1'b0};
      vecs[2] = '{0,   0,   5,  0, 1'b0,   1,     0,  1'b0};
      vecs[3] = '{1,   2,   2,  3, 1'b1,   1,     1,  1'b1};
      vecs[4] = '{0,   4,   2,  0, 1'b0,   4,     3,  1'b0};
      vecs[5] = '{1, 255,   2,  0, 1'b0, 255,   254,  1'b0};
      quick   = '{0,   1,   3,  0, 1'b0,   1,     0,  1'b0};

      #12;
      checkAllZero("in reset");
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkIdle("after reset release");

      for (int i = 0; i < 6; i++) begin
         runVector(vecs[i]);
      end

      // Leave the pointer at 1, then abort a three-block job of requester 0 in its second WAIT.
      runVector(quick);
      busyLen = 20;
      ackDly  = 0;
      stuck   = 1'b0;
      pushStart(2'b01, 1'b1, 1'b0);
      pushStart(2'b01, 1'b0, 1'b0);
      base = startCount;
      applyStimulus(0, 3);
      @(negedge clk);
      checkOutput("abort job gnt", 32'(gnt), 32'h1);
      req[0] = 1'b0;
      n = 0;
      while (startCount < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("second block started", 32'(startCount - base), 32'd2);
      repeat (5) @(negedge clk);
      checkOutput("busy mid job", 32'(busy), 32'd1);
      #3;
      reset = 1'b0;
      #1;
      checkAllZero("async reset");
      startQ.delete();
      endQ.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkIdle("after mid-job reset");

      // Simultaneous requests right after reset: pointer must be back at requester 0.
      busyLen = 10;
      ackDly  = 1;
      pushStart(2'b01, 1'b1, 1'b1);
      pushEnd(2'b01, 1'b0, 2'b01, 11);
      pushStart(2'b10, 1'b1, 1'b1);
      pushEnd(2'b10, 1'b0, 2'b10, 11);
      pushStart(2'b01, 1'b1, 1'b1);
      pushEnd(2'b01, 1'b0, 2'b01, 11);
      @(negedge clk);
      req      = 2'b11;
      req_nblk = {8'd1, 8'd1};
      @(negedge clk);
      checkOutput("simultaneous first gnt", 32'(gnt), 32'h1);
      req[0] = 1'b0;
      waitEnd(200, "job A end seen");
      checkOutput("job A done", 32'(done), 32'h1);
      @(negedge clk);
      checkIdle("gap between jobs");
      @(negedge clk);
      checkOutput("loser granted next", 32'(gnt), 32'h2);
      req[1] = 1'b0;
      repeat (3) @(negedge clk);
      req[0] = 1'b1;
      waitEnd(200, "job B end seen");
      checkOutput("job B done", 32'(done), 32'h2);
      checkOutput("req0 still waiting", 32'(gnt), 32'h2);
      @(negedge clk);
      checkOutput("gap before job C", 32'(gnt), 32'h0);
      @(negedge clk);
      checkOutput("job C gnt", 32'(gnt), 32'h1);
      req[0] = 1'b0;
      waitEnd(200, "job C end seen");
      @(negedge clk);
      checkIdle("after job C");
      checkOutput("final starts drained", 32'(startQ.size()), 32'd0);
      checkOutput("final ends drained", 32'(endQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
